// File: rtl/fc_in_collector.sv
// Serial-to-parallel activation collector feeding the FC layer: fills an IN-entry bank over valid/ready, then holds it until x_ready.
// Optional s_last framing check enabled by defining FC_IN_LAST_CHECK_EN.
module fc_in_collector #(
    parameter int WIDTH = 8,
    parameter int IN    = 400
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] x [0:IN-1],
    output logic             x_valid,
    input  logic             x_ready,
    output logic             frame_err
);
    localparam int IW = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(IN - 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          armed;
    logic          accept;

    // armed holds s_ready low until the first edge after reset release
    assign s_ready = armed && (state == FILL);
    assign accept  = s_valid && s_ready;

`ifdef FC_IN_LAST_CHECK_EN
    logic skip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= '0;
            armed     <= 1'b0;
            x_valid   <= 1'b0;
            frame_err <= 1'b0;
            skip      <= 1'b0;
            for (int unsigned i = 0; i < IN; i++) x[i] <= '0;
        end else begin
            armed <= 1'b1;
            if (clr) begin
                state     <= FILL;
                idx       <= '0;
                x_valid   <= 1'b0;
                frame_err <= 1'b0;
                skip      <= 1'b0;
            end else begin
                case (state)
                    FILL: if (accept) begin
                        // skip: resynchronising after a missing s_last; the s_last sample itself is dropped too
                        if (skip) begin
                            if (s_last) skip <= 1'b0;
                        end else if (s_last != (idx == LAST_IDX)) begin
                            frame_err <= 1'b1;
                            idx       <= '0;
                            skip      <= !s_last;
                        end else begin
                            x[idx] <= s_data;
                            if (idx == LAST_IDX) begin
                                idx     <= '0;
                                state   <= FULL;
                                x_valid <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    FULL: if (x_ready) begin
                        state   <= FILL;
                        x_valid <= 1'b0;
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = s_last;
    assign frame_err   = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL;
            idx     <= '0;
            armed   <= 1'b0;
            x_valid <= 1'b0;
            for (int unsigned i = 0; i < IN; i++) x[i] <= '0;
        end else begin
            armed <= 1'b1;
            if (clr) begin
                state   <= FILL;
                idx     <= '0;
                x_valid <= 1'b0;
            end else begin
                case (state)
                    FILL: if (accept) begin
                        x[idx] <= s_data;
                        if (idx == LAST_IDX) begin
                            idx     <= '0;
                            state   <= FULL;
                            x_valid <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    FULL: if (x_ready) begin
                        state   <= FILL;
                        x_valid <= 1'b0;
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_fc_in_collector.sv
// Randomized self-checking bench for fc_in_collector against a queue-based vector model.
// Framing scenarios run when FC_IN_LAST_CHECK_EN is defined; otherwise s_last is shown to be ignored.
module tb_fc_in_collector;
    localparam int WIDTH = 8;
    localparam int IN    = 400;

    logic             clk = 1'b0;
    logic             rst_n, clr, s_valid, s_last, x_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_ready, x_valid, frame_err;
    logic [WIDTH-1:0] x [0:IN-1];

    int checks = 0;
    int errors = 0;

    // model: samples of the vector in progress, last-written bank contents, and flags
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_vec [0:IN-1];
    bit m_full, m_armed, m_err, m_skip;

    fc_in_collector #(.WIDTH(WIDTH), .IN(IN)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .x(x), .x_valid(x_valid),
        .x_ready(x_ready), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_q.delete();
        m_full = 0; m_armed = 0; m_err = 0; m_skip = 0;
        foreach (m_vec[i]) m_vec[i] = '0;
    endtask

    // One clock: drive at negedge, clock, update model, return at next negedge.
    task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit l, input bit xr, input bit c);
        bit rdy;
        s_valid = v; s_data = d; s_last = l; x_ready = xr; clr = c;
        rdy = m_armed && !m_full;
        @(posedge clk);
        m_armed = 1;
        if (c) begin
            m_q.delete(); m_full = 0; m_err = 0; m_skip = 0;
        end else if (m_full) begin
            if (xr) m_full = 0;
        end else if (rdy && v) begin
`ifdef FC_IN_LAST_CHECK_EN
            if (m_skip) begin
                if (l) m_skip = 0;
            end else if (l != (m_q.size() == IN - 1)) begin
                m_err = 1; m_skip = !l; m_q.delete();
            end else
`endif
            begin
                m_vec[m_q.size()] = d;
                m_q.push_back(d);
                if (m_q.size() == IN) begin
                    m_full = 1;
                    m_q.delete();
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 0; clr = 0; s_valid = 0; s_data = '0; s_last = 0; x_ready = 0;
        model_reset();
        #3;
        bad = 0;
        foreach (x[i]) if (x[i] !== '0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_x: %0d nonzero entries, want 0", bad); end
        checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL reset_xvalid: got %b want 0", x_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_early: got %b want 0", s_ready); end
        cycle(0, '0, 0, 0, 0);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b want 1", s_ready); end
    endtask

    task automatic test_fill_hold();
        int bad;
        for (int i = 0; i < IN; i++) begin
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b want 1", i, s_ready); end
            cycle(1, WIDTH'(i % 256), i == IN - 1, 0, 0);
            checks++; if (x_valid !== (i == IN - 1)) begin errors++; $display("FAIL fill_xvalid[%0d]: got %b want %b", i, x_valid, i == IN - 1); end
        end
        checks++; if (x[90] !== 8'd90) begin errors++; $display("FAIL fill_x90: got %0d want 90", x[90]); end
        checks++; if (x[395] !== 8'd139) begin errors++; $display("FAIL fill_x395: got %0d want 139", x[395]); end
        bad = 0;
        foreach (x[i]) if (x[i] !== m_vec[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL fill_vector: %0d entries differ, want 0", bad); end
        for (int k = 0; k < 4; k++) begin
            cycle(1, 8'hAA, 0, 0, 0);
            checks++; if (s_ready !== 1'b0 || x_valid !== 1'b1 || x[0] !== 8'd0) begin
                errors++; $display("FAIL hold[%0d]: ready %b xvalid %b x0 %h want 0 1 00", k, s_ready, x_valid, x[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] first, d;
        int t, rise, bad;
        first = WIDTH'($urandom_range(0, 255));
        if (first == 8'h55) first = 8'h56;
        cycle(1, 8'h55, 0, 1, 0);
        t = 1; rise = 0;
        checks++; if (x_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_bubble: xvalid %b ready %b want 0 1", x_valid, s_ready);
        end
        for (int i = 0; i < IN; i++) begin
            d = (i == 0) ? first : WIDTH'($urandom);
            cycle(1, d, i == IN - 1, 0, 0);
            t++;
            if (x_valid === 1'b1 && rise == 0) rise = t;
        end
        checks++; if (rise != 401) begin errors++; $display("FAIL b2b_period: got %0d want 401", rise); end
        checks++; if (x[0] !== first) begin errors++; $display("FAIL b2b_x0: got %h want %h", x[0], first); end
        bad = 0;
        foreach (x[i]) if (x[i] !== m_vec[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_vector: %0d entries differ, want 0", bad); end
    endtask

    task automatic test_random_gaps();
        int done, bad, n;
        bit xr;
        cycle(0, '0, 0, 1, 0);
        done = 0;
        for (n = 0; n < 3000 && done < 2; n++) begin
            checks++; if (s_ready !== (m_armed && !m_full)) begin
                errors++; $display("FAIL gaps_ready[%0d]: got %b want %b", n, s_ready, m_armed && !m_full);
            end
            checks++; if (x_valid !== m_full) begin
                errors++; $display("FAIL gaps_xvalid[%0d]: got %b want %b", n, x_valid, m_full);
            end
            xr = $urandom_range(0, 1) != 0;
            if (m_full) begin
                bad = 0;
                foreach (x[i]) if (x[i] !== m_vec[i]) bad++;
                checks++; if (bad != 0) begin errors++; $display("FAIL gaps_vector%0d: %0d entries differ, want 0", done, bad); end
                done++;
                xr = 1;
            end
            cycle($urandom_range(0, 1) != 0, WIDTH'($urandom), (m_q.size() == IN - 1) && !m_skip, xr, 0);
        end
        checks++; if (done != 2) begin errors++; $display("FAIL gaps_timeout: got %0d vectors want 2", done); end
    endtask

    task automatic test_reset_mid();
        int bad;
        for (int i = 0; i < 200; i++) cycle(1, WIDTH'($urandom), 0, 0, 0);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        bad = 0;
        foreach (x[i]) if (x[i] !== '0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_x: %0d nonzero entries, want 0", bad); end
        checks++; if (x_valid !== 1'b0 || s_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_flags: xvalid %b ready %b want 0 0", x_valid, s_ready);
        end
        @(negedge clk);
        rst_n = 1;
        cycle(0, '0, 0, 0, 0);
        for (int i = 0; i < IN; i++) begin
            cycle(1, WIDTH'($urandom), i == IN - 1, 0, 0);
            checks++; if (x_valid !== (i == IN - 1)) begin errors++; $display("FAIL rstmid_xvalid[%0d]: got %b want %b", i, x_valid, i == IN - 1); end
        end
        bad = 0;
        foreach (x[i]) if (x[i] !== m_vec[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_vector: %0d entries differ, want 0", bad); end
    endtask

    task automatic test_clr_last();
        int bad;
        cycle(0, '0, 0, 1, 0);
        for (int i = 0; i < IN - 1; i++) cycle(1, WIDTH'($urandom), 0, 0, 0);
        cycle(1, 8'hEE, 1, 0, 1);
        checks++; if (x_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL clr_flags: xvalid %b ready %b want 0 1", x_valid, s_ready);
        end
        checks++; if (x[IN-1] === 8'hEE) begin errors++; $display("FAIL clr_dropped: got %h want not EE", x[IN-1]); end
        cycle(1, 8'hC3, 0, 0, 0);
        checks++; if (x[0] !== 8'hC3 || x_valid !== 1'b0) begin
            errors++; $display("FAIL clr_restart: x0 %h xvalid %b want C3 0", x[0], x_valid);
        end
        for (int i = 1; i < IN; i++) cycle(1, WIDTH'($urandom), i == IN - 1, 0, 0);
        checks++; if (x_valid !== 1'b1) begin errors++; $display("FAIL clr_complete: got %b want 1", x_valid); end
        bad = 0;
        foreach (x[i]) if (x[i] !== m_vec[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL clr_vector: %0d entries differ, want 0", bad); end
        cycle(0, '0, 0, 1, 0);
    endtask

`ifdef FC_IN_LAST_CHECK_EN
    task automatic test_frame();
        logic [WIDTH-1:0] first;
        int bad;
        cycle(0, '0, 0, 0, 1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_clr0: got %b want 0", frame_err); end
        for (int i = 0; i <= 150; i++) cycle(1, WIDTH'($urandom), i == 150, 0, 0);
        checks++; if (frame_err !== 1'b1 || x_valid !== 1'b0) begin
            errors++; $display("FAIL frame_early: ferr %b xvalid %b want 1 0", frame_err, x_valid);
        end
        for (int i = 0; i < IN; i++) cycle(1, WIDTH'($urandom), i == IN - 1, 0, 0);
        checks++; if (x_valid !== 1'b1 || frame_err !== 1'b1) begin
            errors++; $display("FAIL frame_recover: xvalid %b ferr %b want 1 1", x_valid, frame_err);
        end
        bad = 0;
        foreach (x[i]) if (x[i] !== m_vec[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL frame_vector: %0d entries differ, want 0", bad); end
        cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 0, 0, 1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_clr1: got %b want 0", frame_err); end
        for (int i = 0; i < IN; i++) cycle(1, WIDTH'($urandom), 0, 0, 0);
        checks++; if (frame_err !== 1'b1 || x_valid !== 1'b0) begin
            errors++; $display("FAIL frame_nolast: ferr %b xvalid %b want 1 0", frame_err, x_valid);
        end
        for (int i = 0; i < 6; i++) cycle(1, 8'h77, i == 5, 0, 0);
        first = WIDTH'($urandom_range(0, 255));
        if (first == 8'h77) first = 8'h78;
        for (int i = 0; i < IN; i++) cycle(1, (i == 0) ? first : WIDTH'($urandom), i == IN - 1, 0, 0);
        checks++; if (x_valid !== 1'b1 || x[0] !== first) begin
            errors++; $display("FAIL frame_resync: xvalid %b x0 %h want 1 %h", x_valid, x[0], first);
        end
        bad = 0;
        foreach (x[i]) if (x[i] !== m_vec[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL frame_resync_vector: %0d entries differ, want 0", bad); end
        cycle(0, '0, 0, 0, 1);
        checks++; if (frame_err !== 1'b0 || x_valid !== 1'b0) begin
            errors++; $display("FAIL frame_final_clr: ferr %b xvalid %b want 0 0", frame_err, x_valid);
        end
    endtask
`else
    task automatic test_last_ignored();
        int bad;
        for (int i = 0; i < IN; i++) begin
            cycle(1, WIDTH'($urandom), i == 150, 0, 0);
            checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL last_ferr[%0d]: got %b want 0", i, frame_err); end
        end
        checks++; if (x_valid !== 1'b1) begin errors++; $display("FAIL last_count: got %b want 1", x_valid); end
        bad = 0;
        foreach (x[i]) if (x[i] !== m_vec[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL last_vector: %0d entries differ, want 0", bad); end
        cycle(0, '0, 0, 1, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_fill_hold();
        test_back_to_back();
        test_random_gaps();
        test_reset_mid();
        test_clr_last();
`ifdef FC_IN_LAST_CHECK_EN
        test_frame();
`else
        test_last_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
